aes_round_key_store: RTL and testbench

AES_ROUND_KEY_STORE -- requirements
Module: aes_round_key_store

---
 rtl/aes_round_key_store.sv | 213 +++++++++++++++++++++
 tb/tb_aes_round_key_store.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: holds up to KEY_SLOTS AES key schedules in one RAM
// (slot*16 + index). An independent write FSM loads a schedule beat by
// beat, and a read FSM streams it back in encrypt or decrypt order.
// wr_err and rd_err are registered and pulse on the cycle after the
// rejected start.
module aes_round_key_store #(
  parameter int KEY_SLOTS = 2,
  parameter int KEY_W     = 128,
  localparam int SW       = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 kill,
  input  logic                 wr_start,
  input  logic [SW-1:0]        wr_slot,
  input  logic [1:0]           key_mode,
  input  logic                 wr_valid,
  input  logic [KEY_W-1:0]     wr_key,
  output logic                 wr_busy,
  output logic                 wr_err,
  input  logic                 rd_start,
  input  logic [SW-1:0]        rd_slot,
  input  logic                 rd_dir,
  input  logic                 rd_next,
  output logic [KEY_W-1:0]     rd_key,
  output logic                 rd_valid,
  output logic                 rd_last,
  output logic                 rd_err,
  output logic [KEY_SLOTS-1:0] slot_valid
);

  typedef enum logic { W_IDLE, W_LOAD } w_state_e;
  typedef enum logic { R_IDLE, R_RUN  } r_state_e;

  // Number of round keys for a key size; reserved mode never reaches here.
  function automatic logic [3:0] n_of_mode(input logic [1:0] m);
    case (m)
      2'd1:    return 4'd13;
      2'd2:    return 4'd15;
      default: return 4'd11;
    endcase
  endfunction

  logic [KEY_W-1:0] mem [KEY_SLOTS*16];

  w_state_e w_state_q, w_state_d;
  logic [3:0]    w_idx_q, w_idx_d, w_n_q, w_n_d;
  logic [SW-1:0] w_slot_q, w_slot_d;
  logic          wr_err_q, wr_err_d;
  logic [KEY_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [3:0]    slot_n_q [KEY_SLOTS];
  logic [3:0]    slot_n_d [KEY_SLOTS];

  r_state_e r_state_q, r_state_d;
  logic [3:0]    r_idx_q, r_idx_d, r_n_q, r_n_d;
  logic [SW-1:0] r_slot_q, r_slot_d;
  logic          r_dir_q, r_dir_d;
  logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_err_q, rd_err_d;
  logic [KEY_W-1:0] rd_key_q;

  logic          rd_acc, wr_acc, rd_slot_ok, mem_we, rd_load;
  logic [3:0]    rd_n_sel;
  logic [SW+3:0] w_addr, rd_addr;

  // Start qualification; a read accepted this cycle already counts as active
  // so a same-cycle write to that slot cannot corrupt it.
  always_comb begin
    rd_slot_ok = 1'b0;
    rd_n_sel   = 4'd0;
    for (int i = 0; i < KEY_SLOTS; i++) begin
      if (rd_slot == SW'(i)) begin
        rd_slot_ok = slot_valid_q[i];
        rd_n_sel   = slot_n_q[i];
      end
    end
    rd_acc = rd_start && (r_state_q == R_IDLE) && (int'(rd_slot) < KEY_SLOTS) && rd_slot_ok;
    wr_acc = wr_start && (w_state_q == W_IDLE) && (key_mode != 2'd3) &&
             (int'(wr_slot) < KEY_SLOTS) &&
             !((r_state_q == R_RUN) && (r_slot_q == wr_slot)) &&
             !(rd_acc && (rd_slot == wr_slot));
  end

  // Write FSM: latch slot/N on start, one beat per wr_valid, publish on last beat.
  always_comb begin
    w_state_d    = w_state_q;
    w_idx_d      = w_idx_q;
    w_n_d        = w_n_q;
    w_slot_d     = w_slot_q;
    slot_valid_d = slot_valid_q;
    slot_n_d     = slot_n_q;
    wr_err_d     = wr_start && !wr_acc;
    mem_we       = 1'b0;
    w_addr       = {w_slot_q, w_idx_q};
    case (w_state_q)
      W_IDLE: if (wr_acc) begin
        w_state_d = W_LOAD;
        w_idx_d   = 4'd0;
        w_slot_d  = wr_slot;
        w_n_d     = n_of_mode(key_mode);
        for (int i = 0; i < KEY_SLOTS; i++) begin
          if (wr_slot == SW'(i)) begin
            slot_valid_d[i] = 1'b0;
            slot_n_d[i]     = n_of_mode(key_mode);
          end
        end
      end
      W_LOAD: if (wr_valid) begin
        mem_we = !kill;
        if (w_idx_q == w_n_q - 4'd1) begin
          w_state_d = W_IDLE;
          for (int i = 0; i < KEY_SLOTS; i++)
            if (w_slot_q == SW'(i)) slot_valid_d[i] = 1'b1;
        end else begin
          w_idx_d = w_idx_q + 4'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: pick first index by direction, step on rd_next, stop after last.
  always_comb begin
    r_state_d  = r_state_q;
    r_idx_d    = r_idx_q;
    r_n_d      = r_n_q;
    r_slot_d   = r_slot_q;
    r_dir_d    = r_dir_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_err_d   = rd_start && !rd_acc;
    rd_load    = 1'b0;
    case (r_state_q)
      R_IDLE: if (rd_acc) begin
        r_state_d  = R_RUN;
        r_slot_d   = rd_slot;
        r_dir_d    = rd_dir;
        r_n_d      = rd_n_sel;
        r_idx_d    = rd_dir ? rd_n_sel - 4'd1 : 4'd0;
        rd_valid_d = 1'b1;
        rd_load    = 1'b1;
      end
      R_RUN: if (rd_next) begin
        if (rd_last_q) begin
          r_state_d  = R_IDLE;
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
        end else begin
          r_idx_d = r_dir_q ? r_idx_q - 4'd1 : r_idx_q + 4'd1;
          rd_load = 1'b1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (rd_load) rd_last_d = r_dir_d ? (r_idx_d == 4'd0) : (r_idx_d == r_n_d - 4'd1);
    rd_addr = {r_slot_d, r_idx_d};
  end

  // Control state registers; kill aborts both FSMs and drops all slots.
  always_ff @(posedge clk) begin
    if (kill) begin
      w_state_q    <= W_IDLE;
      w_idx_q      <= '0;
      w_n_q        <= '0;
      w_slot_q     <= '0;
      wr_err_q     <= 1'b0;
      slot_valid_q <= '0;
      for (int i = 0; i < KEY_SLOTS; i++) slot_n_q[i] <= '0;
      r_state_q    <= R_IDLE;
      r_idx_q      <= '0;
      r_n_q        <= '0;
      r_slot_q     <= '0;
      r_dir_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      w_idx_q      <= w_idx_d;
      w_n_q        <= w_n_d;
      w_slot_q     <= w_slot_d;
      wr_err_q     <= wr_err_d;
      slot_valid_q <= slot_valid_d;
      slot_n_q     <= slot_n_d;
      r_state_q    <= r_state_d;
      r_idx_q      <= r_idx_d;
      r_n_q        <= r_n_d;
      r_slot_q     <= r_slot_d;
      r_dir_q      <= r_dir_d;
      rd_valid_q   <= rd_valid_d;
      rd_last_q    <= rd_last_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // RAM write port; contents survive kill and are hidden by slot_valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[w_addr] <= wr_key;
  end

  // RAM synchronous read port doubling as the rd_key register; holds between loads.
  always_ff @(posedge clk) begin
    if (kill)         rd_key_q <= '0;
    else if (rd_load) rd_key_q <= mem[rd_addr];
  end

  assign wr_busy    = (w_state_q == W_LOAD);
  assign wr_err     = wr_err_q;
  assign rd_key     = rd_key_q;
  assign rd_valid   = rd_valid_q;
  assign rd_last    = rd_last_q;
  assign rd_err     = rd_err_q;
  assign slot_valid = slot_valid_q;

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store: inputs change 1ns after a rising
// edge and outputs are sampled 1ns after the following edge.
module tb_aes_round_key_store;
  logic         clk = 1'b0;
  logic         kill, wr_start, wr_valid, wr_busy, wr_err;
  logic [0:0]   wr_slot, rd_slot;
  logic [1:0]   key_mode;
  logic [127:0] wr_key, rd_key;
  logic         rd_start, rd_dir, rd_next, rd_valid, rd_last, rd_err;
  logic [1:0]   slot_valid;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_round_key_store #(.KEY_SLOTS(2), .KEY_W(128)) dut (
    .clk(clk), .kill(kill), .wr_start(wr_start), .wr_slot(wr_slot),
    .key_mode(key_mode), .wr_valid(wr_valid), .wr_key(wr_key),
    .wr_busy(wr_busy), .wr_err(wr_err), .rd_start(rd_start), .rd_slot(rd_slot),
    .rd_dir(rd_dir), .rd_next(rd_next), .rd_key(rd_key), .rd_valid(rd_valid),
    .rd_last(rd_last), .rd_err(rd_err), .slot_valid(slot_valid)
  );

  // Hand-built key pattern: tag s, round i.
  function automatic logic [127:0] kv(input int s, input int i);
    return {32'hA5A5_0000 + 32'(s), 32'(i), 32'hC0DE_0000 ^ 32'(i * 7), 32'h100 * 32'(s) + 32'(i)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wstart(input int slot, input int mode);
    wr_slot = 1'(slot); key_mode = 2'(mode); wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic beats(input int s, input int from, input int upto);
    for (int i = from; i <= upto; i++) begin
      wr_valid = 1'b1; wr_key = kv(s, i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic rstart(input int slot, input logic dir);
    rd_slot = 1'(slot); rd_dir = dir; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
  endtask

  task automatic test_reset();
    kill = 1'b1; tick(); kill = 1'b0;
    n_tests++;
    if ({wr_busy, wr_err, rd_valid, rd_last, rd_err, slot_valid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0", {wr_busy, wr_err, rd_valid, rd_last, rd_err, slot_valid});
    end
    n_tests++;
    if (rd_key !== 128'h0) begin n_fail++; $display("FAIL reset_rd_key: got %h expected 0", rd_key); end
  endtask

  task automatic test_enc128();
    wstart(0, 0);
    n_tests++;
    if (wr_busy !== 1'b1 || wr_err !== 1'b0) begin
      n_fail++; $display("FAIL enc128_busy: got busy=%b err=%b expected busy=1 err=0", wr_busy, wr_err);
    end
    beats(0, 0, 9);
    n_tests++;
    if (slot_valid !== 2'b00) begin n_fail++; $display("FAIL enc128_early_valid: got %b expected 00", slot_valid); end
    beats(0, 10, 10);
    n_tests++;
    if (slot_valid !== 2'b01 || wr_busy !== 1'b0) begin
      n_fail++; $display("FAIL enc128_done: got sv=%b busy=%b expected sv=01 busy=0", slot_valid, wr_busy);
    end
    wr_valid = 1'b1; wr_key = '1; tick(); wr_valid = 1'b0;   // stray beat after load
    rstart(0, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== kv(0, i) || rd_last !== (i == 10)) begin
        n_fail++; $display("FAIL enc128_rd[%0d]: got v=%b last=%b key=%h expected v=1 last=%b key=%h",
                           i, rd_valid, rd_last, rd_key, i == 10, kv(0, i));
      end
      rd_next = 1'b1; tick(); rd_next = 1'b0;
    end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_key !== kv(0, 10)) begin
      n_fail++; $display("FAIL enc128_end: got v=%b last=%b key=%h expected v=0 last=0 key=%h", rd_valid, rd_last, rd_key, kv(0, 10));
    end
    rd_next = 1'b1; tick(); rd_next = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || rd_key !== kv(0, 10)) begin
      n_fail++; $display("FAIL idle_rd_next: got v=%b key=%h expected v=0 key=%h", rd_valid, rd_key, kv(0, 10));
    end
  endtask

  task automatic test_rd_err();
    rstart(1, 1'b0);
    n_tests++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rderr_unwritten: got err=%b v=%b expected err=1 v=0", rd_err, rd_valid);
    end
    tick();
    n_tests++;
    if (rd_err !== 1'b0) begin n_fail++; $display("FAIL rderr_pulse: got %b expected 0", rd_err); end
    rstart(0, 1'b0);
    rstart(0, 1'b1);
    n_tests++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b1 || rd_key !== kv(0, 0) || rd_last !== 1'b0) begin
      n_fail++; $display("FAIL rderr_running: got err=%b v=%b last=%b key=%h expected err=1 v=1 last=0 key=%h",
                         rd_err, rd_valid, rd_last, rd_key, kv(0, 0));
    end
  endtask

  // Runs with the slot-0 read left active by test_rd_err.
  task automatic test_wr_err();
    wstart(0, 0);
    n_tests++;
    if (wr_err !== 1'b1 || wr_busy !== 1'b0 || slot_valid !== 2'b01) begin
      n_fail++; $display("FAIL wrerr_reading: got err=%b busy=%b sv=%b expected err=1 busy=0 sv=01", wr_err, wr_busy, slot_valid);
    end
    tick();
    n_tests++;
    if (wr_err !== 1'b0) begin n_fail++; $display("FAIL wrerr_pulse: got %b expected 0", wr_err); end
    wstart(1, 3);
    n_tests++;
    if (wr_err !== 1'b1 || wr_busy !== 1'b0 || slot_valid !== 2'b01) begin
      n_fail++; $display("FAIL wrerr_mode3: got err=%b busy=%b sv=%b expected err=1 busy=0 sv=01", wr_err, wr_busy, slot_valid);
    end
    for (int i = 0; i < 11; i++) begin rd_next = 1'b1; tick(); end
    rd_next = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wrerr_drain: got v=%b expected 0", rd_valid); end
  endtask

  task automatic test_dec256();
    wstart(1, 2);
    beats(1, 0, 14);
    n_tests++;
    if (slot_valid !== 2'b11) begin n_fail++; $display("FAIL dec256_sv: got %b expected 11", slot_valid); end
    rstart(1, 1'b1);
    for (int i = 14; i >= 0; i--) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== kv(1, i) || rd_last !== (i == 0)) begin
        n_fail++; $display("FAIL dec256_rd[%0d]: got v=%b last=%b key=%h expected v=1 last=%b key=%h",
                           i, rd_valid, rd_last, rd_key, i == 0, kv(1, i));
      end
      rd_next = 1'b1; tick(); rd_next = 1'b0;
    end
    n_tests++;
    if (rd_valid !== 1'b0 || rd_last !== 1'b0) begin
      n_fail++; $display("FAIL dec256_end: got v=%b last=%b expected 0 0", rd_valid, rd_last);
    end
  endtask

  task automatic test_stall_192();
    wstart(1, 1);
    n_tests++;
    if (slot_valid !== 2'b01) begin n_fail++; $display("FAIL s192_clear: got %b expected 01", slot_valid); end
    beats(4, 0, 5);
    wr_key = '1;
    repeat (5) tick();
    n_tests++;
    if (wr_busy !== 1'b1) begin n_fail++; $display("FAIL s192_stall_busy: got %b expected 1", wr_busy); end
    beats(4, 6, 11);
    n_tests++;
    if (slot_valid !== 2'b01 || wr_busy !== 1'b1) begin
      n_fail++; $display("FAIL s192_beat12: got sv=%b busy=%b expected sv=01 busy=1", slot_valid, wr_busy);
    end
    beats(4, 12, 12);
    n_tests++;
    if (slot_valid !== 2'b11 || wr_busy !== 1'b0) begin
      n_fail++; $display("FAIL s192_beat13: got sv=%b busy=%b expected sv=11 busy=0", slot_valid, wr_busy);
    end
    rstart(1, 1'b0);
    for (int i = 0; i <= 12; i++) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== kv(4, i) || rd_last !== (i == 12)) begin
        n_fail++; $display("FAIL s192_rd[%0d]: got v=%b last=%b key=%h expected v=1 last=%b key=%h",
                           i, rd_valid, rd_last, rd_key, i == 12, kv(4, i));
      end
      rd_next = 1'b1; tick(); rd_next = 1'b0;
    end
  endtask

  task automatic test_kill();
    rstart(1, 1'b0);
    rd_next = 1'b1; tick(); rd_next = 1'b0;
    wstart(0, 0);
    n_tests++;
    if (wr_busy !== 1'b1 || rd_valid !== 1'b1 || rd_key !== kv(4, 1)) begin
      n_fail++; $display("FAIL kill_setup: got busy=%b v=%b key=%h expected busy=1 v=1 key=%h", wr_busy, rd_valid, rd_key, kv(4, 1));
    end
    beats(5, 0, 5);
    kill = 1'b1; wr_valid = 1'b1; wr_key = kv(5, 6);
    tick();
    kill = 1'b0; wr_valid = 1'b0;
    n_tests++;
    if ({wr_busy, wr_err, rd_valid, rd_last, rd_err, slot_valid} !== 7'b0 || rd_key !== 128'h0) begin
      n_fail++; $display("FAIL kill_outputs: got flags=%b key=%h expected flags=0 key=0",
                         {wr_busy, wr_err, rd_valid, rd_last, rd_err, slot_valid}, rd_key);
    end
    rstart(0, 1'b0);
    n_tests++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL kill_rd_slot0: got err=%b v=%b expected err=1 v=0", rd_err, rd_valid);
    end
    rstart(1, 1'b0);
    n_tests++;
    if (rd_err !== 1'b1 || rd_valid !== 1'b0 || rd_key !== 128'h0) begin
      n_fail++; $display("FAIL kill_rd_slot1: got err=%b v=%b key=%h expected err=1 v=0 key=0", rd_err, rd_valid, rd_key);
    end
  endtask

  // Reload slot 0, then read it in decrypt order while slot 1 loads alongside.
  task automatic test_back_to_back();
    wstart(0, 0);
    beats(2, 0, 10);
    rstart(0, 1'b1);
    wr_slot = 1'b1; key_mode = 2'd0;
    for (int k = 0; k <= 10; k++) begin
      n_tests++;
      if (rd_valid !== 1'b1 || rd_key !== kv(2, 10 - k) || rd_last !== (k == 10)) begin
        n_fail++; $display("FAIL b2b_rd[%0d]: got v=%b last=%b key=%h expected v=1 last=%b key=%h",
                           k, rd_valid, rd_last, rd_key, k == 10, kv(2, 10 - k));
      end
      rd_next = 1'b1; wr_start = (k == 0); wr_valid = (k >= 1); wr_key = kv(3, k - 1);
      tick();
    end
    rd_next = 1'b0; wr_start = 1'b0; wr_valid = 1'b0;
    n_tests++;
    if (rd_valid !== 1'b0 || slot_valid !== 2'b01 || wr_busy !== 1'b1) begin
      n_fail++; $display("FAIL b2b_mid: got v=%b sv=%b busy=%b expected v=0 sv=01 busy=1", rd_valid, slot_valid, wr_busy);
    end
    beats(3, 10, 10);
    n_tests++;
    if (slot_valid !== 2'b11) begin n_fail++; $display("FAIL b2b_sv: got %b expected 11", slot_valid); end
    rstart(1, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      n_tests++;
      if (rd_key !== kv(3, i) || rd_last !== (i == 10)) begin
        n_fail++; $display("FAIL b2b_rd1[%0d]: got last=%b key=%h expected last=%b key=%h", i, rd_last, rd_key, i == 10, kv(3, i));
      end
      rd_next = 1'b1; tick(); rd_next = 1'b0;
    end
  endtask

  initial begin
    kill = 1'b0; wr_start = 1'b0; wr_slot = '0; key_mode = '0; wr_valid = 1'b0; wr_key = '0;
    rd_start = 1'b0; rd_slot = '0; rd_dir = 1'b0; rd_next = 1'b0;
    #1;
    test_reset();
    test_enc128();
    test_rd_err();
    test_wr_err();
    test_dec256();
    test_stall_192();
    test_kill();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
